// File: rtl/mitm_relay_fifo.sv
// Relay FIFO: buffers words received on the real bus and replays them on a fake interface.
// Optional build macro MITM_RELAY_SUBST_EN swaps popped words equal to match_data for replace_data.
module mitm_relay_fifo #(
  parameter int unsigned NUM_DATA_BITS   = 8,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       recv_new_data,
  input  logic [NUM_DATA_BITS-1:0]   recv_data,
  input  logic [NUM_DATA_BITS-1:0]   match_data,
  input  logic [NUM_DATA_BITS-1:0]   replace_data,
  input  logic                       fake_send_ready,
  input  logic                       fake_send_done,
  output logic                       fake_select,
  output logic                       fake_keep_alive,
  output logic                       fake_send_start,
  output logic [NUM_DATA_BITS-1:0]   fake_send_data,
  output logic                       overflow,
  output logic [FIFO_DEPTH_LOG2:0]   fill_level
);

  localparam int unsigned Depth = 2 ** FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] DepthCount = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {StIdle, StLoad, StStart, StWait} state_e;

  state_e                       state_q, state_d;
  logic [NUM_DATA_BITS-1:0]     mem_q [Depth];
  logic [FIFO_DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]     count_q, count_d;
  logic                         overflow_q, overflow_d;
  logic [NUM_DATA_BITS-1:0]     data_q, data_d;
  logic [NUM_DATA_BITS-1:0]     pop_word;
  logic                         fifo_empty, fifo_full;
  logic                         push_req, push, pop, drop;
  logic                         start;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DepthCount);

  // LOAD is only entered with data available; the empty guard keeps the count from wrapping.
  assign pop      = enable && (state_q == StLoad) && !fifo_empty;
  assign push_req = enable && recv_new_data;
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

`ifdef MITM_RELAY_SUBST_EN
  assign pop_word = (mem_q[rd_ptr_q] == match_data) ? replace_data : mem_q[rd_ptr_q];
`else
  logic unused_subst;
  assign unused_subst = ^{match_data, replace_data};
  assign pop_word     = mem_q[rd_ptr_q];
`endif

  // FIFO bookkeeping; enable=0 empties the buffer synchronously.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    data_d     = data_q;
    if (!enable) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        data_d   = pop_word;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
      if (drop) overflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StLoad;
      end
      StLoad: begin
        state_d = StStart;
      end
      StStart: begin
        if (fake_send_ready) begin
          start   = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (fake_send_done) state_d = fifo_empty ? StIdle : StLoad;
      end
      default: state_d = StIdle;
    endcase
    if (!enable) begin
      state_d = StIdle;
      start   = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      data_q     <= data_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= recv_data;
  end

  assign fake_send_start = start;
  assign fake_send_data  = data_q;
  assign fake_select     = enable && ((state_q != StIdle) || !fifo_empty);
  assign fake_keep_alive = enable && !fifo_empty;
  assign overflow        = overflow_q;
  assign fill_level      = count_q;

  count_bounded_a: assert property (@(posedge sys_clk) disable iff (!rst_n)
    count_q <= DepthCount);
  start_in_start_state_a: assert property (@(posedge sys_clk) disable iff (!rst_n)
    fake_send_start |-> (state_q == StStart));

endmodule

// File: tb/tb_mitm_relay_fifo.sv
// Bench for mitm_relay_fifo: directed corner cases plus randomized traffic scored against a
// word-queue model; honours MITM_RELAY_SUBST_EN the same way the design does.
module tb_mitm_relay_fifo;

  localparam logic [7:0] Match   = 8'h55;
  localparam logic [7:0] Replace = 8'hAA;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       recv_new_data;
  logic [7:0] recv_data;
  logic [7:0] match_data;
  logic [7:0] replace_data;
  logic       fake_send_ready;
  logic       fake_send_done;
  logic       fake_select;
  logic       fake_keep_alive;
  logic       fake_send_start;
  logic [7:0] fake_send_data;
  logic       overflow;
  logic [4:0] fill_level;

  mitm_relay_fifo #(
    .NUM_DATA_BITS  (8),
    .FIFO_DEPTH_LOG2(4)
  ) dut (
    .sys_clk        (sys_clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .recv_new_data  (recv_new_data),
    .recv_data      (recv_data),
    .match_data     (match_data),
    .replace_data   (replace_data),
    .fake_send_ready(fake_send_ready),
    .fake_send_done (fake_send_done),
    .fake_select    (fake_select),
    .fake_keep_alive(fake_keep_alive),
    .fake_send_start(fake_send_start),
    .fake_send_data (fake_send_data),
    .overflow       (overflow),
    .fill_level     (fill_level)
  );

  always #5 sys_clk = ~sys_clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         outstanding = 0;
  bit         inflight    = 1'b0;
  int         done_timer  = 0;
  int         start_cnt   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_word(input logic [7:0] w);
`ifdef MITM_RELAY_SUBST_EN
    return (w == Match) ? Replace : w;
`else
    return w;
`endif
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w, input bit expect_out);
    recv_new_data = 1'b1;
    recv_data     = w;
    if (expect_out) exp_q.push_back(exp_word(w));
    tick();
    recv_new_data = 1'b0;
  endtask

  // Plays the fake interface: random ready, done 1-4 cycles after each start, stray done pulses
  // while nothing is in flight. Every start must carry the next word from the model queue.
  task automatic run(input int n, input bit do_push);
    for (int i = 0; i < n; i++) begin
      recv_new_data = 1'b0;
      if (do_push && outstanding < 13 && $urandom_range(0, 2) == 0) begin
        recv_new_data = 1'b1;
        recv_data     = ($urandom_range(0, 3) == 0) ? Match : 8'($urandom_range(0, 255));
        exp_q.push_back(exp_word(recv_data));
        outstanding++;
      end
      fake_send_ready = ($urandom_range(0, 3) != 0);
      fake_send_done  = 1'b0;
      if (inflight) begin
        if (done_timer == 0) begin
          fake_send_done = 1'b1;
          inflight       = 1'b0;
        end else begin
          done_timer--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        fake_send_done = 1'b1;
      end
      #1;
      if (fake_send_start) begin
        start_cnt++;
        if (exp_q.size() == 0) check_eq("unexpected_start", 32'(fake_send_data), 32'hFFFF_FFFF);
        else check_eq("send_data", 32'(fake_send_data), 32'(exp_q.pop_front()));
        if (outstanding > 0) outstanding--;
        inflight   = 1'b1;
        done_timer = $urandom_range(0, 3);
      end
      @(posedge sys_clk);
      #1;
    end
    recv_new_data   = 1'b0;
    fake_send_done  = 1'b0;
    fake_send_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_fill"}, 32'(fill_level), 32'd0);
    check_eq({tag, "_select"}, 32'(fake_select), 32'd0);
  endtask

  int starts_before;

  initial begin
    rst_n           = 1'b0;
    enable          = 1'b1;
    recv_new_data   = 1'b0;
    recv_data       = '0;
    match_data      = Match;
    replace_data    = Replace;
    fake_send_ready = 1'b0;
    fake_send_done  = 1'b0;
    repeat (2) tick();
    check_eq("rst_fill", 32'(fill_level), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_select", 32'(fake_select), 32'd0);
    check_eq("rst_keep_alive", 32'(fake_keep_alive), 32'd0);
    check_eq("rst_start", 32'(fake_send_start), 32'd0);
    check_eq("rst_data", 32'(fake_send_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single word: start appears two edges after the edge that captures the push.
    fake_send_ready = 1'b1;
    push_word(8'h41, 1'b0);
    check_eq("single_fill1", 32'(fill_level), 32'd1);
    check_eq("single_keep", 32'(fake_keep_alive), 32'd1);
    check_eq("single_start_e0", 32'(fake_send_start), 32'd0);
    tick();
    check_eq("single_start_e1", 32'(fake_send_start), 32'd0);
    tick();
    check_eq("single_start_e2", 32'(fake_send_start), 32'd1);
    check_eq("single_data", 32'(fake_send_data), 32'h41);
    check_eq("single_fill0", 32'(fill_level), 32'd0);
    check_eq("single_select", 32'(fake_select), 32'd1);
    tick();
    check_eq("single_start_once", 32'(fake_send_start), 32'd0);
    fake_send_done = 1'b1;
    #1;
    check_eq("single_select_done", 32'(fake_select), 32'd1);
    tick();
    fake_send_done = 1'b0;
    check_eq("single_select_after", 32'(fake_select), 32'd0);
    check_eq("single_data_hold", 32'(fake_send_data), 32'h41);
    fake_send_ready = 1'b0;

    // Substitution pair.
    push_word(8'h55, 1'b1);
    push_word(8'h12, 1'b1);
    run(100, 1'b0);
    check_idle("subst");

    // One word parked in the sender, then 17 more: 16 fit, the 17th is dropped.
    push_word(8'hA0, 1'b1);
    for (int i = 0; i < 17; i++) push_word(8'(8'hB0 + i), i < 16);
    check_eq("ovf_fill", 32'(fill_level), 32'd16);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    run(400, 1'b0);
    check_idle("ovf_drain");
    check_eq("ovf_sticky", 32'(overflow), 32'd1);

    // Disable with words pending: immediate output drop, flush and overflow clear.
    for (int i = 0; i < 3; i++) push_word(8'(8'h60 + i), 1'b0);
    enable = 1'b0;
    #1;
    check_eq("dis_select_now", 32'(fake_select), 32'd0);
    check_eq("dis_keep_now", 32'(fake_keep_alive), 32'd0);
    tick();
    check_eq("dis_fill", 32'(fill_level), 32'd0);
    check_eq("dis_overflow", 32'(overflow), 32'd0);
    enable = 1'b1;
    repeat (3) tick();
    check_eq("dis_no_resume", 32'(fake_select), 32'd0);

    // Full FIFO, push lands on the pop cycle.
    push_word(8'hC8, 1'b1);
    for (int i = 0; i < 16; i++) push_word(8'(8'hD0 + i), 1'b1);
    check_eq("swap_fill_pre", 32'(fill_level), 32'd16);
    fake_send_ready = 1'b1;
    #1;
    check_eq("swap_start", 32'(fake_send_start), 32'd1);
    check_eq("swap_data", 32'(fake_send_data), 32'(exp_q.pop_front()));
    tick();
    fake_send_ready = 1'b0;
    fake_send_done  = 1'b1;
    tick();
    fake_send_done = 1'b0;
    push_word(8'h3C, 1'b1);
    check_eq("swap_fill", 32'(fill_level), 32'd16);
    check_eq("swap_overflow", 32'(overflow), 32'd0);
    run(400, 1'b0);
    check_idle("swap_drain");

    // Reset while waiting on done with three words queued.
    for (int i = 0; i < 4; i++) push_word(8'(8'h70 + i), 1'b0);
    fake_send_ready = 1'b1;
    #1;
    check_eq("rstmid_start", 32'(fake_send_start), 32'd1);
    tick();
    fake_send_ready = 1'b0;
    check_eq("rstmid_fill", 32'(fill_level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_fill0", 32'(fill_level), 32'd0);
    check_eq("rstmid_select", 32'(fake_select), 32'd0);
    check_eq("rstmid_keep", 32'(fake_keep_alive), 32'd0);
    check_eq("rstmid_start0", 32'(fake_send_start), 32'd0);
    check_eq("rstmid_data", 32'(fake_send_data), 32'd0);
    check_eq("rstmid_ovf", 32'(overflow), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    starts_before = start_cnt;
    run(30, 1'b0);
    check_eq("rstmid_no_start", 32'(start_cnt - starts_before), 32'd0);
    check_idle("rstmid");

    // Randomized traffic, then drain.
    outstanding = 0;
    inflight    = 1'b0;
    run(2000, 1'b1);
    run(400, 1'b0);
    check_idle("rand");
    check_eq("rand_overflow", 32'(overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
